// File: rtl/dram_bus_arbiter.sv
// rtl/dram_bus_arbiter.sv - two-master round-robin arbiter in front of one DRAM controller port
module dram_bus_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              req_read1,
  output logic [DATA_W-1:0] data1,
  output logic              data_valid1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data_in2,
  input  logic              req_read2,
  input  logic              req_write2,
  output logic [DATA_W-1:0] data_out2,
  output logic              data_valid2,
  output logic              write_complete2,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_data_in,
  output logic              dram_req_read,
  output logic              dram_req_write,
  input  logic [DATA_W-1:0] dram_data_out,
  input  logic              dram_data_out_valid,
  input  logic              dram_write_complete
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, WR2} state_t;

  state_t            state, state_n;
  logic              last_grant2, last_grant2_n;
  logic [ADDR_W-1:0] dram_addr_n;
  logic [DATA_W-1:0] dram_data_in_n, data1_n, data_out2_n;
  logic              dram_req_read_n, dram_req_write_n;
  logic              data_valid1_n, data_valid2_n, write_complete2_n;
  logic              req2, grant1;

  // Master 1 wins unless master 2 also asks and master 1 was served last.
  assign req2   = req_read2 | req_write2;
  assign grant1 = req_read1 & (~req2 | last_grant2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_grant2     <= 1'b1;
      dram_addr       <= '0;
      dram_data_in    <= '0;
      dram_req_read   <= 1'b0;
      dram_req_write  <= 1'b0;
      data1           <= '0;
      data_valid1     <= 1'b0;
      data_out2       <= '0;
      data_valid2     <= 1'b0;
      write_complete2 <= 1'b0;
    end else begin
      state           <= state_n;
      last_grant2     <= last_grant2_n;
      dram_addr       <= dram_addr_n;
      dram_data_in    <= dram_data_in_n;
      dram_req_read   <= dram_req_read_n;
      dram_req_write  <= dram_req_write_n;
      data1           <= data1_n;
      data_valid1     <= data_valid1_n;
      data_out2       <= data_out2_n;
      data_valid2     <= data_valid2_n;
      write_complete2 <= write_complete2_n;
    end
  end

  always_comb begin
    state_n           = state;
    last_grant2_n     = last_grant2;
    dram_addr_n       = dram_addr;
    dram_data_in_n    = dram_data_in;
    dram_req_read_n   = 1'b0;
    dram_req_write_n  = 1'b0;
    data1_n           = data1;
    data_valid1_n     = 1'b0;
    data_out2_n       = data_out2;
    data_valid2_n     = 1'b0;
    write_complete2_n = 1'b0;
    case (state)
      IDLE: begin
        if (grant1) begin
          dram_addr_n     = addr1;
          dram_req_read_n = 1'b1;
          last_grant2_n   = 1'b0;
          state_n         = RD1;
        end else if (req2) begin
          dram_addr_n   = addr2;
          last_grant2_n = 1'b1;
          if (req_write2) begin
            dram_data_in_n   = data_in2;
            dram_req_write_n = 1'b1;
            state_n          = WR2;
          end else begin
            dram_req_read_n = 1'b1;
            state_n         = RD2;
          end
        end
      end
      RD1: begin
        if (dram_data_out_valid) begin
          data1_n       = dram_data_out;
          data_valid1_n = 1'b1;
          state_n       = IDLE;
        end
      end
      RD2: begin
        if (dram_data_out_valid) begin
          data_out2_n   = dram_data_out;
          data_valid2_n = 1'b1;
          state_n       = IDLE;
        end
      end
      WR2: begin
        if (dram_write_complete) begin
          write_complete2_n = 1'b1;
          state_n           = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dram_bus_arbiter.sv
// tb/tb_dram_bus_arbiter.sv - scoreboard bench for dram_bus_arbiter with a transaction-level model
module tb_dram_bus_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int K_RD1 = 1, K_RD2 = 2, K_WR2 = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr1 = '0, addr2 = '0;
  logic          req_read1 = 0, req_read2 = 0, req_write2 = 0;
  logic [DW-1:0] data_in2 = '0, dram_data_out = '0;
  logic          dram_data_out_valid = 0, dram_write_complete = 0;
  logic [DW-1:0] data1, data_out2, dram_data_in;
  logic [AW-1:0] dram_addr;
  logic          data_valid1, data_valid2, write_complete2, dram_req_read, dram_req_write;

  dram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .addr1(addr1), .req_read1(req_read1), .data1(data1), .data_valid1(data_valid1),
    .addr2(addr2), .data_in2(data_in2), .req_read2(req_read2), .req_write2(req_write2),
    .data_out2(data_out2), .data_valid2(data_valid2), .write_complete2(write_complete2),
    .dram_addr(dram_addr), .dram_data_in(dram_data_in),
    .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
    .dram_data_out(dram_data_out), .dram_data_out_valid(dram_data_out_valid),
    .dram_write_complete(dram_write_complete)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: one outstanding transaction, round-robin memory of who was served.
  int            cmd_q[$];   // expected transaction kinds, in issue order
  int            resp_q[$];  // expected master-side completion kinds
  bit            m_busy = 0;
  int            m_kind = 0;
  bit            m_last2 = 1;
  int            m_cnt1 = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0, exp_data1 = '0, exp_data2 = '0;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      if (m_busy) begin
        if ((m_kind == K_RD1) && dram_data_out_valid) begin
          exp_data1 = dram_data_out; resp_q.push_back(K_RD1); m_busy = 0;
        end else if ((m_kind == K_RD2) && dram_data_out_valid) begin
          exp_data2 = dram_data_out; resp_q.push_back(K_RD2); m_busy = 0;
        end else if ((m_kind == K_WR2) && dram_write_complete) begin
          resp_q.push_back(K_WR2); m_busy = 0;
        end
      end else if (req_read1 || req_read2 || req_write2) begin
        if (req_read1 && (!(req_read2 || req_write2) || m_last2)) begin
          m_kind = K_RD1; exp_addr = addr1; m_last2 = 0; m_cnt1++;
        end else begin
          exp_addr = addr2; m_last2 = 1;
          if (req_write2) begin m_kind = K_WR2; exp_din = data_in2; end
          else m_kind = K_RD2;
        end
        cmd_q.push_back(m_kind);
        m_busy = 1;
      end
    end
  end

  // DRAM responder knobs
  bit            pend = 0, pend_wr = 0, stray_en = 0, fix_en = 0;
  int            cnt = 0, fix_dly = -1;
  logic [DW-1:0] fix_data = '0;

  task automatic monitor();
    int k;
    if (cmd_q.size() > 0) begin
      k = cmd_q.pop_front();
      chk("cmd_rd", dram_req_read, k != K_WR2);
      chk("cmd_wr", dram_req_write, k == K_WR2);
      pend = 1; pend_wr = (k == K_WR2);
      cnt = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 7);
    end else chk("spurious_cmd", {dram_req_read, dram_req_write}, 0);
    if (resp_q.size() > 0) begin
      k = resp_q.pop_front();
      chk("dv1", data_valid1, k == K_RD1);
      chk("dv2", data_valid2, k == K_RD2);
      chk("wc2", write_complete2, k == K_WR2);
    end else chk("spurious_resp", {data_valid1, data_valid2, write_complete2}, 0);
    chk("dram_addr", dram_addr, exp_addr);
    chk("dram_data_in", dram_data_in, exp_din);
    chk("data1", data1, exp_data1);
    chk("data_out2", data_out2, exp_data2);
  endtask

  task automatic drive_dram();
    bit was_pend;
    was_pend = pend;
    dram_data_out_valid = 0;
    dram_write_complete = 0;
    dram_data_out = $urandom;
    if (pend) begin
      if (cnt == 0) begin
        if (pend_wr) dram_write_complete = 1;
        else begin
          dram_data_out_valid = 1;
          if (fix_en) dram_data_out = fix_data;
        end
        pend = 0;
      end else cnt--;
    end
    // Stray strobes: only the wrong type while a transaction waits, anything otherwise.
    if (stray_en && ($urandom_range(0, 9) == 0)) begin
      if (was_pend) begin
        if (pend_wr) dram_data_out_valid = 1; else dram_write_complete = 1;
      end else if ($urandom_range(0, 1) == 1) dram_data_out_valid = 1;
      else dram_write_complete = 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    drive_dram();
  endtask

  task automatic rand_masters();
    if ($urandom_range(0, 3) == 0) req_read1 = $urandom_range(0, 1);
    if ($urandom_range(0, 3) == 0) req_read2 = $urandom_range(0, 1);
    if ($urandom_range(0, 3) == 0) req_write2 = $urandom_range(0, 1);
    addr1 = AW'($urandom);
    addr2 = AW'($urandom);
    data_in2 = $urandom;
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #1;
    chk("rst_strobes", {dram_req_read, dram_req_write, data_valid1, data_valid2, write_complete2}, 0);
    chk("rst_dram_addr", dram_addr, 0);
    chk("rst_dram_data_in", dram_data_in, 0);
    chk("rst_data1", data1, 0);
    chk("rst_data_out2", data_out2, 0);
    cmd_q.delete(); resp_q.delete();
    m_busy = 0; m_last2 = 1;
    exp_addr = '0; exp_din = '0; exp_data1 = '0; exp_data2 = '0;
    pend = 0;
    req_read1 = 0; req_read2 = 0; req_write2 = 0;
    dram_data_out_valid = 0; dram_write_complete = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_cnt1(input int target);
    for (int i = 0; i < 100 && m_cnt1 < target; i++) step();
    chk("grant1_reached", m_cnt1 >= target, 1);
  endtask

  initial begin
    int target;
    bit found;
    do_reset();

    // Directed: single master-1 read answered after 7 cycles.
    fix_dly = 7; fix_en = 1; fix_data = 32'hdeadbeef;
    addr1 = 24'h00fe00; req_read1 = 1; step(); req_read1 = 0;
    repeat (12) step();
    chk("dir_read1_data", exp_data1, 32'hdeadbeef);

    // Contention after a master-1 read: master-2 write first, then the held master-1 read.
    fix_dly = 3;
    addr1 = 24'h00fe10; addr2 = 24'h003454; data_in2 = 32'h0000feed;
    req_read1 = 1; req_write2 = 1; target = m_cnt1 + 1;
    step(); req_write2 = 0;
    wait_cnt1(target); req_read1 = 0;
    repeat (8) step();
    chk("dir_write_din", exp_din, 32'h0000feed);

    // Master-2 read.
    fix_data = 32'h0badcafe;
    addr2 = 24'h000100; req_read2 = 1; step(); req_read2 = 0;
    repeat (8) step();
    chk("dir_read2_data", exp_data2, 32'h0badcafe);

    // Held master-1 request yields two separate reads.
    req_read1 = 1; target = m_cnt1 + 2;
    wait_cnt1(target); req_read1 = 0;
    repeat (8) step();

    // Randomized traffic with stray strobes.
    fix_dly = -1; fix_en = 0; stray_en = 1;
    repeat (3000) begin rand_masters(); step(); end

    // Reset while master 1 waits for data, then a late data strobe that must be ignored.
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      rand_masters(); step();
      found = m_busy && (m_kind == K_RD1) && pend && (cnt >= 2);
    end
    chk("rd1_wait_found", found, 1);
    stray_en = 0;
    do_reset();
    step();
    dram_data_out_valid = 1; dram_data_out = 32'h12345678;
    repeat (6) step();

    stray_en = 1;
    repeat (3000) begin rand_masters(); step(); end

    stray_en = 0;
    req_read1 = 0; req_read2 = 0; req_write2 = 0;
    repeat (20) step();
    chk("drain_cmd_q", cmd_q.size(), 0);
    chk("drain_resp_q", resp_q.size(), 0);
    chk("drain_idle", m_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
